mem_port_sched: RTL
===================

Name: mem_port_sched

Overview:
- Single-port memory scheduler that shares one 16-bit memory port between N requesters: scalar load/store, vector load, and the vector store sequencer.
- Grants the port round-robin and holds each grant for a whole burst of 1–16 words.
- Generates the address sequence and write strobes for the burst, and returns read data tagged with a valid strobe.
- Sits between the execution units and the data memory. Requesters never drive memory pins directly.

Parameters:
- N, 3, number of requesters (index 0 = scalar, 1 = vector load, 2 = vector store).
- RD_LAT, 2, memory read latency in cycles from address to DataOut (1..4).

Ports:
- Clk  input  1  single clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Req  input  N  per-requester request level; held high until the matching Done.
- ReqWr  input  N  1 = write burst, 0 = read burst; sampled at grant.
- ReqAddr  input  16*N  burst base address, slice i = [16i+15:16i]; sampled at grant.
- ReqLen  input  4*N  burst length; 0 means 16 words, 1..15 literal; sampled at grant.
- ReqWData  input  16*N  write data for the current Beat; sampled combinationally each XFER cycle.
- Grant  output  N  one-hot; high for the granted requester from XFER through DONE.
- Beat  output  4  index of the word currently on the memory port.
- Done  output  N  one-cycle pulse to the granted requester at burst completion.
- RdData  output  16  read data returned to the granted requester.
- RdValid  output  1  RdData qualifier, one per read beat.
- MemEn  output  1  memory access strobe.
- Addr  output  16  memory address.
- WR  output  1  memory write enable.
- DataIn  output  16  memory write data.
- DataOut  input  16  memory read data, valid RD_LAT cycles after its address.

Behaviour:
- Reset (async, Rst_n=0):
  - state = IDLE; Grant, Done, MemEn, WR, RdValid, Beat = 0; Addr, DataIn, RdData = 0.
  - Read-valid pipe cleared; round-robin pointer last = N-1, so requester 0 wins first.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - If any Req is high, select the first set bit scanning last+1, last+2, … mod N.
  - Latch id, base = ReqAddr[id], wr = ReqWr[id], len = ReqLen[id] (0 → 16). Set beat = 0, last = id, next state XFER.
  - No memory activity in IDLE. Arbitration decision costs exactly 1 cycle.
- XFER (one word per cycle):
  - MemEn = 1, Addr = base + beat (mod 2^16, wraps 0xFFFF → 0x0000), WR = wr.
  - DataIn = wr ? ReqWData[id] : 0. Beat = beat. Grant[id] = 1.
  - beat increments each cycle.
  - When beat == len-1: go to DONE if wr, else go to DRAIN.
  - Burst latency is len cycles of XFER.
- Read return:
  - RD_LAT-deep shift register carries (MemEn & ~WR).
  - RdValid = pipe output; RdData = DataOut when RdValid, else 0.
  - Exactly len RdValid pulses per read burst, in address order.
- DRAIN:
  - MemEn = 0, WR = 0.
  - Stay until the read-valid pipe is empty, i.e. the last RdValid has been asserted. The cycle after that, go to DONE.
- DONE:
  - Done[id] = 1 for one cycle; Grant[id] stays 1 this cycle. Next state IDLE.
- Write bursts: Done asserts the cycle after the last write beat.
- Handshake: the requester must deassert Req on the cycle following Done. A Req still high in IDLE is a new request.
- Req deasserted mid-burst is ignored; the burst runs to completion. ReqAddr/ReqLen/ReqWr changes after grant are ignored.
- Simultaneous requests are resolved only in IDLE; there is no preemption. Worst-case wait for any requester is (N-1) × (16 + RD_LAT + 2) cycles.
- len = 1 is a scalar access: 1 XFER cycle, then DRAIN (reads) or DONE.
- Rst_n asserted mid-burst: immediate abort. No Done is issued, in-flight RdValid is suppressed, and the pointer resets to N-1.
- Exactly one Grant bit or none is high at any time. Done is never asserted outside DONE.

Test Plan:
- Single write, Req[2]=1, ReqWr=1, ReqAddr=0x0100, ReqLen=0, ReqWData=0xA000+Beat → 16 XFER cycles with Addr 0x0100..0x010F, WR=1, DataIn 0xA000..0xA00F; Done[2] pulses 1 cycle after the last beat; Grant[2] falls with Done.
- Read, Req[1]=1, ReqAddr=0x0200, ReqLen=4, RD_LAT=2, memory model returns ~Addr → RdValid 4 cycles starting 2 cycles after the first address, RdData 0xFDFF,0xFDFE,0xFDFD,0xFDFC; Done[1] the cycle after the last RdValid.
- All three Req high from reset, each ReqLen=1 → grants in order 0,1,2; re-asserting all three again → order 0,1,2 (pointer rotates); Grant is never two-hot.
- Wrap: ReqAddr=0xFFFE, ReqLen=4, write → Addr 0xFFFE,0xFFFF,0x0000,0x0001.
- Req[0] held high across Done while Req[1] is high → next grant goes to 1, not 0.
- Rst_n pulled low at beat 5 of a 16-beat read → MemEn, Grant, RdValid go to 0 immediately; no Done; after release, a Req[2] write burst completes normally.

Source files
------------

// File: rtl/mem_port_sched.sv
// ---------------------------------------------------------------------------
// mem_port_sched
// Shares one 16-bit single-port data memory between N requesters
// (0 = scalar, 1 = vector load, 2 = vector store). The port is granted
// round-robin and held for a whole burst of 1..16 words. The scheduler
// generates the burst address sequence and write enable, and returns read
// data qualified by a valid strobe.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_req[N]           request level per requester, held until its o_done
//   i_req_wr[N]        1 = write burst, 0 = read burst (sampled at grant)
//   i_req_addr[16*N]   burst base address per requester (sampled at grant)
//   i_req_len[4*N]     burst length, 0 = 16 words (sampled at grant)
//   i_req_wdata[16*N]  write data for the current o_beat (used live in XFER)
//   o_grant[N]         one-hot grant, XFER through DONE
//   o_beat[4]          index of the word currently on the memory port
//   o_done[N]          one-cycle completion pulse to the granted requester
//   o_rd_data[16]      read data, zero when o_rd_valid is low
//   o_rd_valid         one pulse per read beat, in address order
//   o_mem_en, o_addr, o_wr, o_data_in   memory port
//   i_data_out[16]     memory read data, RD_LAT cycles after its address
// ---------------------------------------------------------------------------
module mem_port_sched #(
  parameter int N      = 3,
  parameter int RD_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N-1:0]      i_req,
  input  logic [N-1:0]      i_req_wr,
  input  logic [16*N-1:0]   i_req_addr,
  input  logic [4*N-1:0]    i_req_len,
  input  logic [16*N-1:0]   i_req_wdata,
  output logic [N-1:0]      o_grant,
  output logic [3:0]        o_beat,
  output logic [N-1:0]      o_done,
  output logic [15:0]       o_rd_data,
  output logic              o_rd_valid,
  output logic              o_mem_en,
  output logic [15:0]       o_addr,
  output logic              o_wr,
  output logic [15:0]       o_data_in,
  input  logic [15:0]       i_data_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_id;
  logic [IW-1:0]     r_last;
  logic              r_wr;
  logic [4:0]        r_len;       // 1..16
  logic [RD_LAT-1:0] r_rd_pipe;   // bit 0 is the beat returning this cycle

  logic [IW-1:0]     w_sel;
  logic              w_any;
  logic              w_sel_wr;
  logic [15:0]       w_sel_addr;
  logic [3:0]        w_sel_len;
  logic              w_last_beat;
  logic              w_pipe_rest;
  logic [RD_LAT-1:0] w_pipe_next;

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    onehot = N'(1) << idx;
  endfunction

  // Round-robin pick: scanning k = N-1 down to 0 lets the nearest requester
  // after r_last overwrite any farther one.
  always_comb begin
    w_sel = r_last;
    w_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_any = w_any | i_req[(int'(r_last) + 1 + k) % N];
      w_sel = i_req[(int'(r_last) + 1 + k) % N] ? IW'((int'(r_last) + 1 + k) % N) : w_sel;
    end
  end

  assign w_sel_wr    = i_req_wr[w_sel];
  assign w_sel_addr  = i_req_addr[16*int'(w_sel) +: 16];
  assign w_sel_len   = i_req_len[4*int'(w_sel) +: 4];
  assign w_last_beat = ({1'b0, o_beat} == (r_len - 5'd1));
  // Beats still in flight behind the one returning now; zero means the
  // current RdValid (if any) is the last one.
  assign w_pipe_rest = |(r_rd_pipe >> 1);
  assign w_pipe_next = RD_LAT'({o_mem_en & ~o_wr, r_rd_pipe} >> 1);

  assign o_rd_valid = r_rd_pipe[0];
  assign o_rd_data  = r_rd_pipe[0] ? i_data_out : 16'd0;
  // Write data follows the requester's live data for the beat shown on o_beat.
  assign o_data_in  = (o_mem_en & o_wr) ? i_req_wdata[16*int'(r_id) +: 16] : 16'd0;

  // Read-valid shift register: one entry per issued read address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe <= w_pipe_next;
    end
  end

  // Scheduler FSM with registered port and handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_id     <= '0;
      r_last   <= IW'(N - 1);
      r_wr     <= 1'b0;
      r_len    <= 5'd0;
      o_grant  <= '0;
      o_done   <= '0;
      o_mem_en <= 1'b0;
      o_wr     <= 1'b0;
      o_addr   <= 16'd0;
      o_beat   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done  <= '0;
          o_grant <= '0;
          if (w_any) begin
            r_id     <= w_sel;
            r_last   <= w_sel;
            r_wr     <= w_sel_wr;
            r_len    <= (w_sel_len == 4'd0) ? 5'd16 : {1'b0, w_sel_len};
            o_grant  <= onehot(w_sel);
            o_mem_en <= 1'b1;
            o_wr     <= w_sel_wr;
            o_addr   <= w_sel_addr;
            o_beat   <= 4'd0;
            r_state  <= S_XFER;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_XFER: begin
          if (w_last_beat) begin
            o_mem_en <= 1'b0;
            o_wr     <= 1'b0;
            o_addr   <= 16'd0;
            o_beat   <= 4'd0;
            if (r_wr) begin
              o_done  <= onehot(r_id);
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            o_beat <= o_beat + 4'd1;
            o_addr <= o_addr + 16'd1;   // wraps 0xFFFF -> 0x0000
          end
        end
        S_DRAIN: begin
          if (!w_pipe_rest) begin
            o_done  <= onehot(r_id);
            r_state <= S_DONE;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          o_done  <= '0;
          o_grant <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          o_done   <= '0;
          o_grant  <= '0;
          o_mem_en <= 1'b0;
          o_wr     <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
